interrupt_service_ctrl: RTL and testbench
=========================================

Name: interrupt_service_ctrl

Overview:
Consumer side of the interrupt-flag path. It latches the eight per-source interrupt flags (external INT0/1, pin-change 0..2, Timer0 COMPA/COMPB/OVF) into a pending register and arbitrates among them by fixed priority. It raises a request/acknowledge handshake toward the RISC-V core fetch unit, supplies the vector address, and pulses a one-hot clear back to the flag owners. It tracks in-service state until the core signals return-from-interrupt, so it blocks nesting.

Parameters:
N_SRC, 8, number of interrupt sources; bit 0 has the highest priority.
ADDR_W, 32, vector address width.
VEC_BASE, 32'h0000_0000, vector table base address; slot 0 is the reset vector.
VEC_STRIDE, 4, byte distance between vector slots.
MISS_W, 8, width of the saturating missed-event counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high.
INT_EN  in  1  global interrupt enable, driven by the core CSR.
src_flag  in  N_SRC  source flags, ordered INTF0, INTF1, PCIF0, PCIF1, PCIF2, TIMER0_COMPA, TIMER0_COMPB, TIMER0_OVF (bit 0..7).
src_mask  in  N_SRC  per-source enable; 1 = enabled.
irq_ack  in  1  core accepts the request and jumps to the vector.
irq_ret  in  1  one-cycle pulse when the core retires RETI/MRET.
irq_req  out  1  interrupt request to the core.
irq_id  out  3  index of the granted source; width is clog2(N_SRC).
irq_vector  out  ADDR_W  VEC_BASE + (irq_id+1)*VEC_STRIDE.
flag_clr  out  N_SRC  one-cycle one-hot clear pulse to the source flag owner.
in_service  out  1  a handler is active.
pending  out  N_SRC  pending register.
miss_cnt  out  MISS_W  count of events lost because the source's bit was already pending.

Behaviour:
- Reset (synchronous, one cycle): state=IDLE; pending, src_d, irq_req, irq_id, irq_vector, flag_clr, in_service and miss_cnt all 0.
- Pending update, every cycle:
  - rise = src_flag & ~src_d.
  - pending_next = (pending & ~clr_now) | rise. Set wins over clear on the same bit.
  - A rise on a bit already pending, and not cleared this cycle, increments miss_cnt. miss_cnt saturates at all-ones.
- Arbitration: cand = pending & src_mask. The winner is the lowest set index. Arbitration is combinational from registered pending.
- FSM, state IDLE:
  - If INT_EN and cand != 0, go to REQ next cycle.
  - irq_id and irq_vector are registered at this transition and held constant throughout REQ.
- FSM, state REQ:
  - irq_req=1.
  - On irq_ack: go to SERVICE, assert flag_clr[irq_id] for exactly one cycle, and clear pending[irq_id] in the same cycle (clr_now).
  - Else if INT_EN=0 or src_mask[irq_id]=0: withdraw and return to IDLE. irq_req drops next cycle, pending is untouched.
  - If irq_ack and withdrawal occur in the same cycle, the ack wins.
  - There is no preemption: a higher-priority arrival during REQ waits.
- FSM, state SERVICE:
  - in_service=1, irq_req=0.
  - On irq_ret, go to IDLE; a new request can start the following cycle (no extra bubble).
  - New events during SERVICE accumulate in pending.
- Ignored inputs: irq_ack in IDLE or SERVICE; irq_ret in IDLE or REQ.
- Latency: source edge → pending is 1 cycle; pending → irq_req is 1 cycle; ack → flag_clr is registered, 1 cycle.
- Reset asserted in any state returns to IDLE next edge; it aborts service and drops pending events.

Decomposition:
- Shared package irq_pkg:
  - state encoding (IDLE, REQ, SERVICE);
  - source index constants (SRC_INT0=0 … SRC_T0_OVF=7);
  - N_SRC.
- One sub-module: irq_prio_enc, a parameterized lowest-index-first priority encoder producing valid and index. Everything else lives in the top module.

Test Plan:
1. Single source: reset, INT_EN=1, mask=FF, rise on src_flag[7] → pending=80 after 1 cycle; irq_req next cycle with irq_id=7 and irq_vector=0x20. Ack → flag_clr=80 for one cycle, in_service=1. Ret → IDLE.
2. Priority: rises on bits 5 and 2 in the same cycle → grant id=2 (vector 0x0C). After ack and ret, grant id=5 (vector 0x18) with no extra idle cycle.
3. Lock and no preemption: in REQ for id=6, bit 0 rises → id stays 6 through ack. Bit 0 is granted after ret.
4. Withdrawal: in REQ, drop INT_EN without ack → irq_req=0 next cycle and pending is unchanged. Raise INT_EN again → re-request for the same id.
5. Collision and miss: during SERVICE, toggle bit 3 twice → pending[3]=1 and miss_cnt=1. Drive 300 misses → miss_cnt saturates at FF. Rise on the bit being cleared in the ack cycle → pending stays 1.
6. Reset mid-SERVICE with pending=0x11 → next cycle state IDLE, pending=0, in_service=0, irq_req=0. Spurious irq_ack/irq_ret in IDLE → no change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt service controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_pkg;

  localparam int N_SRC = 8;

  // Source bit positions; lower index means higher priority.
  localparam int SRC_INT0    = 0;
  localparam int SRC_INT1    = 1;
  localparam int SRC_PCINT0  = 2;
  localparam int SRC_PCINT1  = 3;
  localparam int SRC_PCINT2  = 4;
  localparam int SRC_T0_COMPA = 5;
  localparam int SRC_T0_COMPB = 6;
  localparam int SRC_T0_OVF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder producing a valid flag and the winning index.
// Latency: purely combinational.
// Backpressure: none; output follows the request vector every cycle.
module irq_prio_enc #(
  parameter int W    = 8,
  parameter int ID_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]    req,
  output logic            vld,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_service_ctrl.sv
// Latches interrupt flag edges, arbitrates by fixed priority and runs the req/ack/ret handshake with the core.
// Latency: flag edge -> pending 1 cycle, pending -> irq_req 1 cycle, irq_ack -> flag_clr 1 cycle.
// Backpressure: irq_req is held with a fixed id/vector until irq_ack or withdrawal; no nesting until irq_ret.
module interrupt_service_ctrl #(
  parameter int               N_SRC      = irq_pkg::N_SRC,
  parameter int               ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE  = '0,
  parameter int               VEC_STRIDE = 4,
  parameter int               MISS_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       INT_EN,
  input  logic [N_SRC-1:0]           src_flag,
  input  logic [N_SRC-1:0]           src_mask,
  input  logic                       irq_ack,
  input  logic                       irq_ret,
  output logic                       irq_req,
  output logic [$clog2(N_SRC)-1:0]   irq_id,
  output logic [ADDR_W-1:0]          irq_vector,
  output logic [N_SRC-1:0]           flag_clr,
  output logic                       in_service,
  output logic [N_SRC-1:0]           pending,
  output logic [MISS_W-1:0]          miss_cnt
);

  import irq_pkg::*;

  localparam int ID_W = $clog2(N_SRC);

  state_t             state;
  logic [N_SRC-1:0]   src_d;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   clr_now;
  logic [N_SRC-1:0]   collide;
  logic               enc_vld;
  logic [ID_W-1:0]    enc_idx;
  logic [ADDR_W-1:0]  enc_vector;
  logic [MISS_W:0]    miss_sum;
  logic [MISS_W-1:0]  miss_next;
  logic               take_ack;
  logic               withdraw;

  assign rise     = src_flag & ~src_d;
  assign cand     = pending & src_mask;
  assign take_ack = (state == ST_REQ) && irq_ack;
  assign withdraw = (state == ST_REQ) && (!INT_EN || !src_mask[irq_id]);
  // The granted bit is cleared in the ack cycle itself; a fresh rise on it still sets it again.
  assign clr_now  = take_ack ? (N_SRC'(1) << irq_id) : '0;
  assign collide  = rise & pending & ~clr_now;

  irq_prio_enc #(
    .W    (N_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req (cand),
    .vld (enc_vld),
    .idx (enc_idx)
  );

  // Slot 0 holds the reset vector, so source n lives in slot n+1.
  assign enc_vector = VEC_BASE + ADDR_W'((int'(enc_idx) + 1) * VEC_STRIDE);

  // Count every lost event this cycle and saturate at all-ones.
  always_comb begin
    miss_sum = {1'b0, miss_cnt};
    for (int i = 0; i < N_SRC; i++) begin
      if (collide[i]) miss_sum = miss_sum + (MISS_W + 1)'(1);
    end
    miss_next = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
  end

  // Edge capture, pending register, clear pulse and missed-event counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d    <= '0;
      pending  <= '0;
      flag_clr <= '0;
      miss_cnt <= '0;
    end else begin
      src_d    <= src_flag;
      pending  <= (pending & ~clr_now) | rise;
      flag_clr <= clr_now;
      miss_cnt <= miss_next;
    end
  end

  // Request/service handshake with registered outputs; id and vector are frozen on entry to REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_vector <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (INT_EN && enc_vld) begin
            state      <= ST_REQ;
            irq_req    <= 1'b1;
            irq_id     <= enc_idx;
            irq_vector <= enc_vector;
          end
        end
        ST_REQ: begin
          if (take_ack) begin
            state      <= ST_SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (withdraw) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_ret) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_service_ctrl.sv
// Randomized plus directed stimulus for interrupt_service_ctrl against a transaction-level reference.
// Latency: expectations are pushed at the driving negedge and checked 1 time unit after the next posedge.
// Backpressure: the bench plays the core, acking and returning at random times.
module tb_interrupt_service_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        INT_EN;
  logic [7:0]  src_flag;
  logic [7:0]  src_mask;
  logic        irq_ack;
  logic        irq_ret;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [31:0] irq_vector;
  logic [7:0]  flag_clr;
  logic        in_service;
  logic [7:0]  pending;
  logic [7:0]  miss_cnt;

  always #5 clk = ~clk;

  interrupt_service_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .INT_EN     (INT_EN),
    .src_flag   (src_flag),
    .src_mask   (src_mask),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .flag_clr   (flag_clr),
    .in_service (in_service),
    .pending    (pending),
    .miss_cnt   (miss_cnt)
  );

  typedef struct {
    logic [7:0]  pend;
    logic [7:0]  miss;
    logic        insvc;
    logic        req;
    logic [7:0]  clr;
    logic [2:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Stimulus levels held between steps.
  logic       g_en   = 1'b0;
  logic [7:0] g_flag = 8'h00;
  logic [7:0] g_mask = 8'hFF;

  // Reference model: who is asking, who is being served, what is waiting.
  bit         m_asking;
  bit         m_serving;
  int         m_id;
  bit [7:0]   m_pend;
  bit [7:0]   m_prev;
  int         m_miss;
  bit [7:0]   m_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the coming edge.
  task automatic step(input bit rst, input bit ack, input bit ret);
    bit [7:0] rise;
    exp_t     e;
    @(negedge clk);
    reset    = rst;
    INT_EN   = g_en;
    src_flag = g_flag;
    src_mask = g_mask;
    irq_ack  = ack;
    irq_ret  = ret;
    if (rst) begin
      m_asking = 0; m_serving = 0; m_id = 0;
      m_pend = 0; m_prev = 0; m_miss = 0; m_clr = 0;
    end else begin
      rise  = g_flag & ~m_prev;
      m_clr = 8'h00;
      if (m_asking) begin
        if (ack) begin
          m_clr     = 8'(1 << m_id);
          m_asking  = 0;
          m_serving = 1;
        end else if (!g_en || !g_mask[m_id]) begin
          m_asking = 0;
        end
      end else if (m_serving) begin
        if (ret) m_serving = 0;
      end else if (g_en && ((m_pend & g_mask) != 0)) begin
        for (int i = 7; i >= 0; i--)
          if (m_pend[i] && g_mask[i]) m_id = i;
        m_asking = 1;
      end
      for (int i = 0; i < 8; i++)
        if (rise[i] && m_pend[i] && !m_clr[i] && m_miss < 255) m_miss++;
      m_pend = (m_pend & ~m_clr) | rise;
      m_prev = g_flag;
    end
    e.pend  = m_pend;
    e.miss  = 8'(m_miss);
    e.insvc = m_serving;
    e.req   = m_asking;
    e.clr   = m_clr;
    e.id    = 3'(m_id);
    e.vec   = 32'((m_id + 1) * 4);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Monitor: pops one expectation per observed cycle and compares the visible outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pending",    32'(pending),    32'(e.pend));
        chk("miss_cnt",   32'(miss_cnt),   32'(e.miss));
        chk("in_service", 32'(in_service), 32'(e.insvc));
        chk("irq_req",    32'(irq_req),    32'(e.req));
        chk("flag_clr",   32'(flag_clr),   32'(e.clr));
        if (e.req) begin
          chk("irq_id",     32'(irq_id), 32'(e.id));
          chk("irq_vector", irq_vector,  e.vec);
        end
      end
    end
  end

  initial begin
    logic [7:0] tog;
    reset = 1'b1; INT_EN = 1'b0; src_flag = '0; src_mask = '0;
    irq_ack = 1'b0; irq_ret = 1'b0;

    // Single source on bit 7.
    step(1, 0, 0); step(1, 0, 0);
    g_en = 1; g_mask = 8'hFF; g_flag = 8'h00;
    idle(2);
    g_flag = 8'h80; idle(3);
    step(0, 1, 0); idle(2);
    step(0, 0, 1); g_flag = 8'h00; idle(2);

    // Two simultaneous sources: 2 first, 5 right after return.
    g_flag = 8'h24; idle(3);
    step(0, 1, 0); idle(1); step(0, 0, 1);
    idle(2); step(0, 1, 0); step(0, 0, 1);
    g_flag = 8'h00; idle(2);

    // Lock on id 6 while bit 0 arrives.
    g_flag = 8'h40; idle(3);
    g_flag = 8'h41; idle(2);
    step(0, 1, 0); idle(1); step(0, 0, 1);
    idle(3); step(0, 1, 0); step(0, 0, 1);
    g_flag = 8'h00; idle(2);

    // Withdrawal by dropping INT_EN, then re-request.
    g_flag = 8'h02; idle(3);
    g_en = 0; idle(2);
    g_en = 1; idle(2);
    step(0, 1, 0); step(0, 0, 1);
    g_flag = 8'h00; idle(2);

    // Collisions during service, saturation, and a rise on the bit being cleared.
    g_flag = 8'h01; idle(3);
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin g_flag = g_flag ^ 8'h08; idle(1); end
    for (int i = 0; i < 620; i++) begin g_flag = g_flag ^ 8'h08; idle(1); end
    g_flag = 8'h00; step(0, 0, 1); idle(2);
    step(0, 1, 0); step(0, 0, 1);
    g_flag = 8'h08; idle(3);
    g_flag = 8'h00; idle(2);
    g_flag = 8'h08; step(0, 1, 0);
    g_flag = 8'h00; idle(1); step(0, 0, 1); idle(2);
    step(0, 1, 0); step(0, 0, 1); idle(2);

    // Reset during service with pending 0x11, then spurious ack/ret in IDLE.
    g_flag = 8'h04; idle(3);
    step(0, 1, 0);
    g_flag = 8'h15; idle(2);
    g_flag = 8'h00; step(1, 0, 0);
    g_en = 0; step(0, 1, 0); step(0, 0, 1); step(0, 1, 1); idle(2);

    // Random traffic.
    g_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) g_mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      g_en = ($urandom_range(0, 9) != 0);
      tog = 8'($urandom & $urandom & $urandom);
      g_flag = g_flag ^ tog;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(2);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
